hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter MUL_LAT, 5, cycles a multiply occupies HI/LO after issue.
REQ-002 Parameter DIV_LAT, 33, cycles a divide occupies HI/LO after issue.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 idValid  input  1  decode stage holds a valid instruction.
REQ-006 idRs, idRt  input  5 each  source register numbers of the decode instruction.
REQ-007 idUseRs, idUseRt, idUseLo, idUseHi  input  1 each  register-use flags from the decode-stage use decoder.
REQ-008 idWriteReg  input  5  GPR destination; 0 = no GPR write.
REQ-009 idIsLoad  input  1  instruction is a memory load.
REQ-010 idMulDiv, idIsDiv  input  1 each  instruction starts a multi-cycle HI/LO op; idIsDiv selects divide latency.
REQ-011 flush  input  1  kill the decode instruction (branch redirect/exception).
REQ-012 stall  output  1  hold PC/IF/ID, insert bubble into EX.
REQ-013 fwdRs, fwdRt  output  2 each  operand source: 0 regfile, 1 EX, 2 MEM, 3 WB.
REQ-014 hiloBusy  output  1  multi-cycle HI/LO op in flight.

Function
REQ-015 Three shadow entries (EX, MEM, WB), each holding valid, dst[4:0], isLoad.
REQ-016 accept = idValid & ~stall & ~flush.
REQ-017 Each cycle: WB<=MEM, MEM<=EX; EX<=decode fields when accept, else EX.valid<=0 (bubble).
REQ-018 A source is active when its use flag is 1, idValid is 1 and the register number is nonzero.
REQ-019 Match on a stage = entry valid & entry dst nonzero & dst equals the active source number.
REQ-020 fwdRs/fwdRt combinational, priority EX(1) > MEM(2) > WB(3) > regfile(0); inactive source gives 0.
REQ-021 Load-use: stall=1 when either active source matches EX and EX.isLoad=1; MEM/WB loads forward without stalling.
REQ-022 HI/LO counter, 6 bits: loaded with MUL_LAT or DIV_LAT (per idIsDiv) on accept with idMulDiv=1; otherwise decrements by 1 while nonzero; saturates at 0.
REQ-023 hiloBusy = (counter != 0), registered view.
REQ-024 HI/LO hazard: stall=1 when idValid & counter!=0 & (idUseLo | idUseHi | idMulDiv).
REQ-025 stall = (load-use | HI/LO hazard) & ~flush; flush has priority and forces stall=0.
REQ-026 flush never cancels an issued mul/div; counter continues.
REQ-027 idValid=0 forces stall=0 and fwdRs=fwdRt=0.
REQ-028 Counter reaching 0 and a dependent decode instruction in the same cycle: instruction sees counter value before update; stalls that cycle, proceeds next.
REQ-029 Fields of EX/MEM/WB with valid=0 never produce a match.

Reset
REQ-030 On reset: all entries valid=0, dst=0, isLoad=0; counter=0.
REQ-031 Outputs during and after reset: stall=0, fwdRs=fwdRt=0, hiloBusy=0.
REQ-032 Reset asserted mid mul/div clears counter in one cycle; no residual stall.

Verification
REQ-033 Accept writer dst=8, next instr rs=8 useRs=1 -> fwdRs=1; one cycle later fwdRs=2; then 3; then 0.
REQ-034 Load dst=9, next instr rt=9 useRt=1 -> stall=1 for exactly 1 cycle, then fwdRt=2, stall=0.
REQ-035 Writer dst=0, reader rs=0 -> fwdRs=0, stall=0.
REQ-036 Accept MULT, next MFLO (idUseLo=1) -> hiloBusy=1, stall=1 for 5 cycles, MFLO accepted on cycle 6; DIV -> 33 cycles.
REQ-037 Load-use stall cycle with flush=1 -> stall=0, EX bubble, no accept.
REQ-038 DIV issued, reset asserted at cycle 10 -> next cycle hiloBusy=0, stall=0, all fwd=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage hazard unit for a 5-stage pipeline. Shadows the destination
//   register of the instructions in EX, MEM and WB. For the decode
//   instruction it selects operand forwarding sources and raises stall on a
//   load-use hazard or on HI/LO access while a multiply/divide is in flight.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   idValid                     decode stage holds a valid instruction
//   idRs, idRt                  source register numbers
//   idUseRs/Rt/Lo/Hi            source-use flags
//   idWriteReg                  GPR destination (0 = none)
//   idIsLoad                    instruction is a load
//   idMulDiv, idIsDiv           starts a multi-cycle HI/LO op; divide select
//   flush                       kill decode instruction
//   stall                       hold PC/IF/ID, bubble into EX
//   fwdRs, fwdRt                0 regfile, 1 EX, 2 MEM, 3 WB
//   hiloBusy                    multi-cycle HI/LO op in flight
module hazard_scoreboard #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       idValid,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUseRs,
  input  logic       idUseRt,
  input  logic       idUseLo,
  input  logic       idUseHi,
  input  logic [4:0] idWriteReg,
  input  logic       idIsLoad,
  input  logic       idMulDiv,
  input  logic       idIsDiv,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fwdRs,
  output logic [1:0] fwdRt,
  output logic       hiloBusy
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       isLoad;
  } entry_t;

  typedef enum logic [1:0] {
    SRC_RF  = 2'd0,
    SRC_EX  = 2'd1,
    SRC_MEM = 2'd2,
    SRC_WB  = 2'd3
  } fwd_src_e;

  entry_t     ex, mem, wb;
  logic [5:0] hiloCnt;

  logic       rsAct, rtAct;
  logic       rsEx, rsMem, rsWb;
  logic       rtEx, rtMem, rtWb;
  logic       loadUse, hiloHaz, stallInt, accept;
  fwd_src_e   rsSrc, rtSrc;

  function automatic logic hit(input entry_t e, input logic [4:0] r);
    return e.valid && (e.dst != '0) && (e.dst == r);
  endfunction

  function automatic fwd_src_e pick(input logic act, input logic hEx,
                                    input logic hMem, input logic hWb);
    if (!act)      return SRC_RF;
    else if (hEx)  return SRC_EX;
    else if (hMem) return SRC_MEM;
    else if (hWb)  return SRC_WB;
    else           return SRC_RF;
  endfunction

  always_comb begin
    rsAct = idValid & idUseRs & (idRs != '0);
    rtAct = idValid & idUseRt & (idRt != '0);

    rsEx  = rsAct & hit(ex,  idRs);
    rsMem = rsAct & hit(mem, idRs);
    rsWb  = rsAct & hit(wb,  idRs);
    rtEx  = rtAct & hit(ex,  idRt);
    rtMem = rtAct & hit(mem, idRt);
    rtWb  = rtAct & hit(wb,  idRt);

    rsSrc = pick(rsAct, rsEx, rsMem, rsWb);
    rtSrc = pick(rtAct, rtEx, rtMem, rtWb);

    loadUse  = (rsEx | rtEx) & ex.isLoad;
    // Uses the counter value before this cycle's update, so an instruction
    // arriving as the counter expires still waits one more cycle.
    hiloHaz  = idValid & (hiloCnt != '0) & (idUseLo | idUseHi | idMulDiv);
    stallInt = (loadUse | hiloHaz) & ~flush;
    accept   = idValid & ~stallInt & ~flush;

    // Outputs are held quiet while reset is asserted.
    stall    = stallInt & ~reset;
    fwdRs    = reset ? SRC_RF : rsSrc;
    fwdRt    = reset ? SRC_RF : rtSrc;
    hiloBusy = (hiloCnt != '0) & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex      <= '0;
      mem     <= '0;
      wb      <= '0;
      hiloCnt <= '0;
    end else begin
      wb  <= mem;
      mem <= ex;
      if (accept) begin
        ex.valid  <= 1'b1;
        ex.dst    <= idWriteReg;
        ex.isLoad <= idIsLoad;
      end else begin
        ex <= '0;
      end

      // Flush only blocks a new issue; an op already counting keeps going.
      if (accept && idMulDiv)
        hiloCnt <= idIsDiv ? 6'(DIV_LAT) : 6'(MUL_LAT);
      else if (hiloCnt != '0)
        hiloCnt <= hiloCnt - 6'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       idValid;
  logic [4:0] idRs, idRt, idWriteReg;
  logic       idUseRs, idUseRt, idUseLo, idUseHi;
  logic       idIsLoad, idMulDiv, idIsDiv, flush;
  logic       stall, hiloBusy;
  logic [1:0] fwdRs, fwdRt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.MUL_LAT(5), .DIV_LAT(33)) dut (
    .clk(clk), .reset(reset), .idValid(idValid),
    .idRs(idRs), .idRt(idRt),
    .idUseRs(idUseRs), .idUseRt(idUseRt), .idUseLo(idUseLo), .idUseHi(idUseHi),
    .idWriteReg(idWriteReg), .idIsLoad(idIsLoad),
    .idMulDiv(idMulDiv), .idIsDiv(idIsDiv), .flush(flush),
    .stall(stall), .fwdRs(fwdRs), .fwdRt(fwdRt), .hiloBusy(hiloBusy)
  );

  typedef struct {
    string      tag;
    logic       stall;
    logic [1:0] fr;
    logic [1:0] ft;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs are already driven; queue the expectation, sample mid-cycle,
  // then advance past the next rising edge.
  task automatic step(input string tag, input logic es, input logic [1:0] efr,
                      input logic [1:0] eft, input logic eb);
    exp_t e;
    exp_q.push_back('{tag, es, efr, eft, eb});
    @(negedge clk);
    e = exp_q.pop_front();
    check({e.tag, ".stall"},    {31'd0, stall},    {31'd0, e.stall});
    check({e.tag, ".fwdRs"},    {30'd0, fwdRs},    {30'd0, e.fr});
    check({e.tag, ".fwdRt"},    {30'd0, fwdRt},    {30'd0, e.ft});
    check({e.tag, ".hiloBusy"}, {31'd0, hiloBusy}, {31'd0, e.busy});
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    idValid = 0; idRs = 0; idRt = 0; idUseRs = 0; idUseRt = 0;
    idUseLo = 0; idUseHi = 0; idWriteReg = 0; idIsLoad = 0;
    idMulDiv = 0; idIsDiv = 0; flush = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic [4:0] wr, input logic ld);
    nop();
    idValid = 1; idRs = rs; idRt = rt; idUseRs = urs; idUseRt = urt;
    idWriteReg = wr; idIsLoad = ld;
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 3; i++) step("drain", 0, 0, 0, 0);
  endtask

  initial begin
    nop();
    reset = 1;
    instr(8, 8, 1, 1, 0, 0);
    step("reset0", 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0);
    reset = 0;
    drain();

    // Forwarding walks EX -> MEM -> WB -> regfile
    instr(0, 0, 0, 0, 8, 0);  step("w8", 0, 0, 0, 0);
    instr(8, 0, 1, 0, 0, 0);
    step("fwd_ex",  0, 1, 0, 0);
    step("fwd_mem", 0, 2, 0, 0);
    step("fwd_wb",  0, 3, 0, 0);
    step("fwd_rf",  0, 0, 0, 0);
    drain();

    // Youngest writer wins
    instr(0, 0, 0, 0, 8, 0);  step("w8a", 0, 0, 0, 0);
    instr(0, 0, 0, 0, 8, 0);  step("w8b", 0, 0, 0, 0);
    instr(8, 8, 1, 1, 0, 0);  step("prio", 0, 1, 1, 0);
    drain();

    // Load-use: one stall, then forward from MEM
    instr(0, 0, 0, 0, 9, 1);  step("ld9", 0, 0, 0, 0);
    instr(0, 9, 0, 1, 0, 0);
    step("lu_stall", 1, 0, 1, 0);
    step("lu_go",    0, 0, 2, 0);
    drain();

    // idValid=0 masks everything
    instr(0, 0, 0, 0, 9, 1);  step("ld9b", 0, 0, 0, 0);
    instr(0, 9, 0, 1, 0, 0);  idValid = 0;
    step("novalid", 0, 0, 0, 0);
    drain();

    // r0 never matches, even from a load
    instr(0, 0, 0, 0, 0, 1);  step("w0", 0, 0, 0, 0);
    instr(0, 0, 1, 1, 0, 0);  step("r0", 0, 0, 0, 0);
    drain();

    // Flush in a load-use cycle: no stall, no accept
    instr(0, 0, 0, 0, 9, 1);  step("ld9c", 0, 0, 0, 0);
    instr(0, 9, 0, 1, 12, 0); flush = 1;
    step("flush_lu", 0, 0, 1, 0);
    instr(12, 9, 1, 1, 0, 0);
    step("after_flush", 0, 0, 2, 0);
    drain();

    // MULT then MFLO: 5 stall cycles
    instr(0, 0, 0, 0, 0, 0);  idMulDiv = 1;
    step("mult", 0, 0, 0, 0);
    instr(0, 0, 0, 0, 3, 0);  idUseLo = 1;
    for (int i = 0; i < 5; i++) step("mflo_wait", 1, 0, 0, 1);
    step("mflo_go", 0, 0, 0, 0);
    drain();

    // DIV then MFHI: 33 cycles busy, a flush mid-way does not cancel it
    instr(0, 0, 0, 0, 0, 0);  idMulDiv = 1; idIsDiv = 1;
    step("div", 0, 0, 0, 0);
    instr(0, 0, 0, 0, 4, 0);  idUseHi = 1;
    for (int i = 0; i < 10; i++) step("mfhi_wait", 1, 0, 0, 1);
    flush = 1;
    step("div_flush", 0, 0, 0, 1);
    flush = 0;
    for (int i = 0; i < 22; i++) step("mfhi_wait2", 1, 0, 0, 1);
    step("mfhi_go", 0, 0, 0, 0);
    drain();

    // Reset mid-divide clears the counter at once
    instr(0, 0, 0, 0, 0, 0);  idMulDiv = 1; idIsDiv = 1;
    step("div2", 0, 0, 0, 0);
    instr(0, 0, 0, 0, 4, 0);  idUseHi = 1;
    for (int i = 0; i < 9; i++) step("div2_wait", 1, 0, 0, 1);
    reset = 1;
    step("rst_mid", 0, 0, 0, 0);
    reset = 0;
    step("post_rst", 0, 0, 0, 0);
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
